// File: rtl/cce_alu_issue.sv
// Operand-issue/writeback stage for the CCE ALU: one issue register, ALU sees op the cycle after accept.
// Retire writes the GPR on the next unstalled edge with full bypass; stall_i freezes a valid op and drops ready_o.
module cce_alu_issue #(
  parameter int width_p    = 16,
  parameter int gpr_els_p  = 8,
  parameter int op_width_p = 4,
  localparam int gpr_addr_w = $clog2(gpr_els_p)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  v_i,
  output logic                  ready_o,
  input  logic [op_width_p-1:0] alu_op_i,
  input  logic [gpr_addr_w-1:0] rs_a_i,
  input  logic [gpr_addr_w-1:0] rs_b_i,
  input  logic                  imm_v_i,
  input  logic [width_p-1:0]    imm_i,
  input  logic [gpr_addr_w-1:0] rd_i,
  input  logic                  wr_v_i,
  input  logic                  stall_i,
  output logic                  alu_v_o,
  output logic [op_width_p-1:0] alu_op_o,
  output logic [width_p-1:0]    alu_opd_a_o,
  output logic [width_p-1:0]    alu_opd_b_o,
  input  logic [width_p-1:0]    alu_res_i,
  input  logic                  alu_branch_res_i,
  output logic                  branch_v_o,
  output logic                  branch_taken_o
);

  typedef struct packed {
    logic                  v;
    logic [op_width_p-1:0] op;
    logic [width_p-1:0]    opd_a;
    logic [width_p-1:0]    opd_b;
    logic [gpr_addr_w-1:0] rd;
    logic                  wr_v;
  } iss_t;

  iss_t               iss_q, iss_d;
  logic [width_p-1:0] gpr_q [gpr_els_p];

  logic               advance, accept, retire_wr;
  logic               byp_a, byp_b;
  logic [width_p-1:0] opd_a, opd_b;

  assign advance   = ~stall_i;
  assign ready_o   = ~iss_q.v | ~stall_i;
  assign accept    = v_i & ready_o;
  assign retire_wr = iss_q.v & iss_q.wr_v & advance;

  // The retiring result is not in the GPR array yet, so dependent ops take it straight from the ALU.
  assign byp_a = retire_wr & (iss_q.rd == rs_a_i);
  assign byp_b = retire_wr & ~imm_v_i & (iss_q.rd == rs_b_i);
  assign opd_a = byp_a ? alu_res_i : gpr_q[rs_a_i];
  assign opd_b = imm_v_i ? imm_i : (byp_b ? alu_res_i : gpr_q[rs_b_i]);

  always_comb begin
    iss_d = iss_q;
    if (accept) begin
      iss_d.v     = 1'b1;
      iss_d.op    = alu_op_i;
      iss_d.opd_a = opd_a;
      iss_d.opd_b = opd_b;
      iss_d.rd    = rd_i;
      iss_d.wr_v  = wr_v_i;
    end else if (advance) begin
      iss_d.v = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iss_q <= '0;
    end else begin
      iss_q <= iss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < gpr_els_p; i++) begin
        gpr_q[i] <= '0;
      end
    end else if (retire_wr) begin
      gpr_q[iss_q.rd] <= alu_res_i;
    end
  end

  assign alu_v_o        = iss_q.v;
  assign alu_op_o       = iss_q.op;
  assign alu_opd_a_o    = iss_q.opd_a;
  assign alu_opd_b_o    = iss_q.opd_b;
  assign branch_v_o     = iss_q.v & ~iss_q.wr_v;
  assign branch_taken_o = alu_branch_res_i & branch_v_o;

endmodule

// File: tb/tb_cce_alu_issue.sv
// Bench for cce_alu_issue: a behavioural ALU closes the loop; an in-order architectural model predicts operands.
module tb_cce_alu_issue;
  localparam int W = 16, N = 8, AW = 3, OW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          v_i, ready_o, imm_v_i, wr_v_i, stall_i;
  logic [OW-1:0] alu_op_i, alu_op_o;
  logic [AW-1:0] rs_a_i, rs_b_i, rd_i;
  logic [W-1:0]  imm_i, alu_opd_a_o, alu_opd_b_o, alu_res;
  logic          alu_v_o, alu_br, branch_v_o, branch_taken_o;

  int tests = 0;
  int fails = 0;

  // Architectural register contents after every accepted op, plus expected issue outputs.
  logic [W-1:0]  gpr_m [N];
  logic          m_v, m_wr;
  logic [OW-1:0] m_op;
  logic [W-1:0]  m_a, m_b;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [OW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a & b;
      4'd4:    return b;
      default: return a | b;
    endcase
  endfunction

  assign alu_res = alu_v_o ? alu_f(alu_op_o, alu_opd_a_o, alu_opd_b_o) : '0;
  assign alu_br  = alu_v_o & (alu_opd_a_o == alu_opd_b_o);

  cce_alu_issue #(.width_p(W), .gpr_els_p(N), .op_width_p(OW)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .ready_o(ready_o),
    .alu_op_i(alu_op_i), .rs_a_i(rs_a_i), .rs_b_i(rs_b_i),
    .imm_v_i(imm_v_i), .imm_i(imm_i), .rd_i(rd_i), .wr_v_i(wr_v_i),
    .stall_i(stall_i), .alu_v_o(alu_v_o), .alu_op_o(alu_op_o),
    .alu_opd_a_o(alu_opd_a_o), .alu_opd_b_o(alu_opd_b_o),
    .alu_res_i(alu_res), .alu_branch_res_i(alu_br),
    .branch_v_o(branch_v_o), .branch_taken_o(branch_taken_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) gpr_m[i] = '0;
    m_v = 1'b0; m_wr = 1'b0; m_op = '0; m_a = '0; m_b = '0;
  endtask

  // One clock: drive inputs, check outputs at the falling edge, then advance the model.
  task automatic step(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] ra,
                      input logic [AW-1:0] rb, input logic iv, input logic [W-1:0] im,
                      input logic [AW-1:0] rd, input logic wr, input logic st);
    logic exp_ready, acc;
    logic [W-1:0] a, b;
    v_i = v; alu_op_i = op; rs_a_i = ra; rs_b_i = rb; imm_v_i = iv;
    imm_i = im; rd_i = rd; wr_v_i = wr; stall_i = st;
    @(negedge clk);
    exp_ready = !m_v || !st;
    chk("ready_o", 32'(ready_o), 32'(exp_ready));
    chk("alu_v_o", 32'(alu_v_o), 32'(m_v));
    chk("alu_op_o", 32'(alu_op_o), 32'(m_op));
    chk("alu_opd_a_o", 32'(alu_opd_a_o), 32'(m_a));
    chk("alu_opd_b_o", 32'(alu_opd_b_o), 32'(m_b));
    chk("branch_v_o", 32'(branch_v_o), 32'(m_v && !m_wr));
    chk("branch_taken_o", 32'(branch_taken_o), 32'(m_v && !m_wr && (m_a == m_b)));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      a = gpr_m[ra];
      b = iv ? im : gpr_m[rb];
      m_v = 1'b1; m_wr = wr; m_op = op; m_a = a; m_b = b;
      if (wr) gpr_m[rd] = alu_f(op, a, b);
    end else if (!st) begin
      m_v = 1'b0;
    end
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0);
  endtask

  // Branch-type read (no write) of two registers: exposes their values on the operand outputs.
  task automatic rd2(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b1, 4'd1, ra, rb, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic v, input logic st);
    v_i = v; stall_i = st; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; v_i = 1'b0; stall_i = 1'b0;
    model_clear();
  endtask

  initial begin
    logic          rv, riv, rwr, rst;
    logic [OW-1:0] rop;
    logic [AW-1:0] rra, rrb, rrd;
    logic [W-1:0]  rim;

    model_clear();
    v_i = 1'b0; alu_op_i = '0; rs_a_i = '0; rs_b_i = '0; imm_v_i = 1'b0;
    imm_i = '0; rd_i = '0; wr_v_i = 1'b0; stall_i = 1'b0; reset = 1'b1;
    repeat (2) @(posedge clk);
    do_reset(1'b0, 1'b0);

    // Reset state, then every GPR reads zero (equal operands also make these taken branches).
    idle();
    for (int r = 0; r < N; r += 2) rd2(AW'(r), AW'(r + 1));
    idle();

    // Dependent ADD chain through bypass.
    step(1'b1, 4'd0, 3'd0, 3'd0, 1'b1, 16'd5, 3'd1, 1'b1, 1'b0);
    step(1'b1, 4'd0, 3'd1, 3'd0, 1'b1, 16'd3, 3'd2, 1'b1, 1'b0);
    rd2(3'd2, 3'd1);
    idle();

    // Branch with unequal operands, then equal ones.
    rd2(3'd1, 3'd2);
    rd2(3'd2, 3'd2);
    idle();

    // Stall with a valid op held for three cycles, dependent op waiting upstream.
    step(1'b1, 4'd0, 3'd1, 3'd0, 1'b1, 16'd7, 3'd5, 1'b1, 1'b0);
    repeat (3) step(1'b1, 4'd0, 3'd5, 3'd5, 1'b0, 16'd0, 3'd6, 1'b1, 1'b1);
    step(1'b1, 4'd0, 3'd5, 3'd5, 1'b0, 16'd0, 3'd6, 1'b1, 1'b0);
    rd2(3'd6, 3'd5);
    idle();

    // Stall with an empty stage still accepts, then holds.
    step(1'b1, 4'd2, 3'd6, 3'd5, 1'b0, 16'd0, 3'd7, 1'b1, 1'b1);
    step(1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 3'd0, 3'd0, 1'b0, 16'd0, 3'd0, 1'b0, 1'b0);
    rd2(3'd7, 3'd7);
    idle();

    // Reset while an op writing r3 is in flight, with stall and valid high.
    step(1'b1, 4'd4, 3'd0, 3'd0, 1'b1, 16'h00AA, 3'd3, 1'b1, 1'b0);
    step(1'b1, 4'd4, 3'd0, 3'd0, 1'b1, 16'h1234, 3'd3, 1'b1, 1'b0);
    do_reset(1'b1, 1'b1);
    idle();
    rd2(3'd3, 3'd1);
    rd2(3'd5, 3'd7);
    idle();

    // r4 = 0xFFFF then r4 = r4 - r4 with both operands bypassed.
    step(1'b1, 4'd4, 3'd0, 3'd0, 1'b1, 16'hFFFF, 3'd4, 1'b1, 1'b0);
    step(1'b1, 4'd1, 3'd4, 3'd4, 1'b0, 16'd0, 3'd4, 1'b1, 1'b0);
    rd2(3'd4, 3'd0);
    idle();

    // Random traffic against the architectural model.
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 3) != 0);
      rop = OW'($urandom_range(0, 5));
      rra = AW'($urandom_range(0, N - 1));
      rrb = AW'($urandom_range(0, N - 1));
      riv = ($urandom_range(0, 1) != 0);
      rim = W'($urandom);
      rrd = AW'($urandom_range(0, N - 1));
      rwr = ($urandom_range(0, 4) != 0);
      rst = ($urandom_range(0, 3) == 0);
      step(rv, rop, rra, rrb, riv, rim, rrd, rwr, rst);
      if (i % 150 == 149) do_reset(rv, rst);
    end
    idle();
    for (int r = 0; r < N; r += 2) rd2(AW'(r), AW'(r + 1));
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
